// File: rtl/iomem_stats_poller.sv
// iomem_stats_poller: sweeps per-PHY gray monitor counters over iomem and
// accumulates wrap-safe binary deltas into 32-bit totals.
module iomem_stats_poller #(
    parameter logic [31:0] BASE_ADDR     = 32'h0300_0000,
    parameter int          PHY_NUM       = 4,
    parameter int          POLL_INTERVAL = 1000,
    parameter int          TIMEOUT       = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    output logic        iomem_valid,
    input  logic        iomem_ready,
    output logic [3:0]  iomem_wstrb,
    output logic [31:0] iomem_addr,
    output logic [31:0] iomem_wdata,
    input  logic [31:0] iomem_rdata,
    input  logic [4:0]  sel,
    output logic [31:0] total,
    output logic        sweep_done,
    output logic        timeout_err,
    output logic [15:0] timeout_count
);
    localparam int IW = $clog2(POLL_INTERVAL + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [IW-1:0] PI = IW'(POLL_INTERVAL);
    localparam logic [TW-1:0] TL = TW'(TIMEOUT - 1);
    localparam logic [4:0] NS = 5'(4 * PHY_NUM);
    localparam logic [3:0] LAST = 4'(4 * PHY_NUM - 1);
    localparam logic [2:0] S_IDLE = 3'd0, S_REQ = 3'd1, S_LATCH = 3'd2, S_ABORT = 3'd3, S_NEXT = 3'd4;
    logic [2:0] state;
    logic [3:0] idx;
    logic [IW-1:0] icnt;
    logic [TW-1:0] wcnt;
    logic [15:0] gray_q, bin, delta;
    logic [31:0] tot [16];
    logic [15:0] last [16];
    logic [15:0] primed;
    logic unused_hi;
    function automatic logic [15:0] g2b(input logic [15:0] g);
        logic [15:0] b;
        b[15] = g[15];
        for (int i = 14; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction
    assign unused_hi = ^iomem_rdata[31:16];
    assign bin = g2b(gray_q);
    assign delta = bin - last[idx];
    assign iomem_valid = state == S_REQ;
    assign iomem_addr = iomem_valid ? BASE_ADDR + {22'b0, idx[3:2], 4'b0, idx[1:0], 2'b0} : 32'b0;
    assign iomem_wstrb = 4'b0;
    assign iomem_wdata = 32'b0;
    assign timeout_err = state == S_ABORT;
    assign sweep_done = state == S_NEXT && idx == LAST;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            idx <= '0;
            icnt <= '0;
            wcnt <= '0;
            gray_q <= '0;
            primed <= '0;
            timeout_count <= '0;
            total <= '0;
            for (int i = 0; i < 16; i++) begin
                tot[i] <= '0;
                last[i] <= '0;
            end
        end else begin
            total <= sel < NS ? tot[sel[3:0]] : 32'b0;
            case (state)
                S_IDLE: begin
                    if (icnt != PI) icnt <= icnt + 1'b1;
                    if (enable && icnt == PI) begin
                        state <= S_REQ;
                        wcnt <= '0;
                    end
                end
                S_REQ: begin
                    if (iomem_ready) begin
                        gray_q <= {iomem_rdata[7:0], iomem_rdata[15:8]};
                        state <= S_LATCH;
                    end else if (wcnt >= TL) state <= S_ABORT;
                    else wcnt <= wcnt + 1'b1;
                end
                S_LATCH: begin
                    // first read of an index only establishes the baseline
                    if (primed[idx]) tot[idx] <= tot[idx] + {16'b0, delta};
                    last[idx] <= bin;
                    primed[idx] <= 1'b1;
                    state <= S_NEXT;
                end
                S_ABORT: begin
                    if (timeout_count != 16'hFFFF) timeout_count <= timeout_count + 1'b1;
                    state <= S_NEXT;
                end
                S_NEXT: begin
                    if (idx == LAST) begin
                        idx <= '0;
                        icnt <= '0;
                        state <= S_IDLE;
                    end else begin
                        idx <= idx + 1'b1;
                        wcnt <= '0;
                        state <= enable ? S_REQ : S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_iomem_stats_poller.sv
// tb_iomem_stats_poller: directed sweeps against a gray-coding iomem responder
// model, with table-driven readout of the accumulated totals.
module tb_iomem_stats_poller;
    logic clk = 1'b0, rst, enable, iomem_valid, iomem_ready, sweep_done, timeout_err;
    logic [3:0] iomem_wstrb;
    logic [31:0] iomem_addr, iomem_wdata, iomem_rdata, total;
    logic [4:0] sel;
    logic [15:0] timeout_count;
    int total_n = 0, bad_n = 0;
    logic [15:0] val [16];
    logic silent [16];
    int lat, done_cnt, terr_cnt, v7_cnt, rcnt;
    logic logging, prev_valid, prev_ready;
    logic [31:0] prev_addr;
    logic [31:0] alog [$];
    logic [15:0] g;
    logic [3:0] ai;
    typedef struct {int ph; logic [4:0] sel; logic [31:0] exp;} vec_t;
    vec_t vt [19];
    logic [31:0] exp_addr [16];

    iomem_stats_poller #(.POLL_INTERVAL(20), .TIMEOUT(64)) dut (
        .clk(clk), .rst(rst), .enable(enable), .iomem_valid(iomem_valid), .iomem_ready(iomem_ready),
        .iomem_wstrb(iomem_wstrb), .iomem_addr(iomem_addr), .iomem_wdata(iomem_wdata),
        .iomem_rdata(iomem_rdata), .sel(sel), .total(total), .sweep_done(sweep_done),
        .timeout_err(timeout_err), .timeout_count(timeout_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_n++;
        if (act !== exp) begin
            bad_n++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic timeout_fail(input string nm);
        total_n++;
        bad_n++;
        $display("FAIL %s: event not seen within cycle budget", nm);
    endtask

    task automatic run_sweep(input string nm);
        int k = 0;
        enable = 1'b1;
        do begin
            @(negedge clk);
            k++;
        end while (!sweep_done && k < 5000);
        if (!sweep_done) timeout_fail(nm);
        enable = 1'b0;
    endtask

    task automatic rd(input logic [4:0] s, input logic [31:0] exp, input string nm);
        @(negedge clk);
        sel = s;
        @(negedge clk);
        chk(nm, total, exp);
    endtask

    task automatic check_phase(input int p);
        for (int i = 0; i < 19; i++)
            if (vt[i].ph == p) rd(vt[i].sel, vt[i].exp, $sformatf("total_p%0d_sel%0d", p, vt[i].sel));
    endtask

    // bus monitor and responder share one process so ready/valid ordering is deterministic
    initial begin
        iomem_ready = 1'b0;
        iomem_rdata = '0;
        prev_valid = 1'b0;
        prev_ready = 1'b0;
        prev_addr = '0;
        rcnt = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (sweep_done) done_cnt++;
                if (timeout_err) terr_cnt++;
                if (iomem_valid && iomem_addr == 32'h0300_010C) v7_cnt++;
                if (iomem_valid && !prev_valid && logging) alog.push_back(iomem_addr);
                if (iomem_valid) chk("wstrb", {28'b0, iomem_wstrb}, 32'd0);
                if (prev_valid && prev_ready) chk("valid_drop_after_ready", {31'b0, iomem_valid}, 32'd0);
                else if (prev_valid && iomem_valid) chk("addr_stable", iomem_addr, prev_addr);
            end
            if (iomem_ready) begin
                iomem_ready = 1'b0;
                iomem_rdata = '0;
                rcnt = 0;
            end else if (iomem_valid) begin
                rcnt++;
                ai = {iomem_addr[9:8], iomem_addr[3:2]};
                if (rcnt >= lat && !silent[ai]) begin
                    g = val[ai] ^ (val[ai] >> 1);
                    iomem_ready = 1'b1;
                    iomem_rdata = {16'hDEAD, g[7:0], g[15:8]};
                end
            end else rcnt = 0;
            prev_valid = iomem_valid && !rst;
            prev_addr = iomem_addr;
            prev_ready = iomem_ready;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, vseen;
        vt = '{'{2, 0, 5}, '{2, 1, 0}, '{2, 5, 4}, '{2, 7, 3}, '{2, 10, 234}, '{2, 15, 65535},
               '{2, 16, 0}, '{2, 31, 0}, '{3, 0, 7}, '{3, 7, 3}, '{3, 10, 234},
               '{4, 3, 9}, '{4, 7, 104}, '{4, 5, 4}, '{6, 0, 0}, '{6, 5, 0}, '{6, 7, 0},
               '{7, 0, 3}, '{7, 5, 0}};
        exp_addr = '{32'h0300_0000, 32'h0300_0004, 32'h0300_0008, 32'h0300_000C,
                     32'h0300_0100, 32'h0300_0104, 32'h0300_0108, 32'h0300_010C,
                     32'h0300_0200, 32'h0300_0204, 32'h0300_0208, 32'h0300_020C,
                     32'h0300_0300, 32'h0300_0304, 32'h0300_0308, 32'h0300_030C};
        for (int i = 0; i < 16; i++) begin
            val[i] = '0;
            silent[i] = 1'b0;
        end
        lat = 1;
        done_cnt = 0;
        terr_cnt = 0;
        v7_cnt = 0;
        logging = 1'b0;
        enable = 1'b0;
        sel = '0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_valid", {31'b0, iomem_valid}, 32'd0);
        chk("rst_addr", iomem_addr, 32'd0);
        chk("rst_wstrb", {28'b0, iomem_wstrb}, 32'd0);
        chk("rst_wdata", iomem_wdata, 32'd0);
        chk("rst_total", total, 32'd0);
        chk("rst_sweep_done", {31'b0, sweep_done}, 32'd0);
        chk("rst_timeout_err", {31'b0, timeout_err}, 32'd0);
        chk("rst_timeout_count", {16'b0, timeout_count}, 32'd0);
        rst = 1'b0;
        // sweep 1: baselines, address order
        val[5] = 16'hFFFE;
        val[10] = 16'd1000;
        val[15] = 16'h8000;
        logging = 1'b1;
        run_sweep("sweep1");
        logging = 1'b0;
        chk("addr_count", alog.size(), 32'd16);
        for (int i = 0; i < 16 && i < alog.size(); i++) chk($sformatf("addr_%0d", i), alog[i], exp_addr[i]);
        // sweep 2: deltas, including a 16-bit wrap
        val[0] = 16'd5;
        val[5] = 16'h0002;
        val[7] = 16'd3;
        val[10] = 16'd1234;
        val[15] = 16'h7FFF;
        run_sweep("sweep2");
        chk("sweep_done_pulses", done_cnt, 32'd2);
        check_phase(2);
        // sweep 3: idx 7 never answers
        val[0] = 16'd7;
        val[7] = 16'd100;
        silent[7] = 1'b1;
        v7_cnt = 0;
        run_sweep("sweep3");
        chk("idx7_valid_cycles", v7_cnt, 32'd64);
        chk("timeout_err_pulses", terr_cnt, 32'd1);
        chk("timeout_count", {16'b0, timeout_count}, 32'd1);
        check_phase(3);
        // sweep 4: enable drops during idx 3 request
        silent[7] = 1'b0;
        val[7] = 16'd104;
        val[3] = 16'd9;
        lat = 3;
        enable = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!(iomem_valid && iomem_addr == 32'h0300_000C) && k < 500);
        if (!(iomem_valid && iomem_addr == 32'h0300_000C)) timeout_fail("idx3_request");
        enable = 1'b0;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (iomem_valid && k < 100);
        if (iomem_valid) timeout_fail("idx3_complete");
        vseen = 0;
        repeat (60) begin
            @(negedge clk);
            if (iomem_valid) vseen++;
        end
        chk("no_valid_while_disabled", vseen, 32'd0);
        rd(5'd3, 32'd9, "idx3_completed_total");
        enable = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!iomem_valid && k < 200);
        if (!iomem_valid) timeout_fail("resume_request");
        chk("resume_addr", iomem_addr, 32'h0300_0100);
        run_sweep("sweep4");
        check_phase(4);
        // reset in the middle of a request
        lat = 1;
        val[0] = 16'd50;
        val[5] = 16'd77;
        enable = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!iomem_valid && k < 200);
        if (!iomem_valid) timeout_fail("pre_reset_request");
        rst = 1'b1;
        #1;
        chk("async_rst_valid", {31'b0, iomem_valid}, 32'd0);
        chk("async_rst_total", total, 32'd0);
        chk("async_rst_timeout_count", {16'b0, timeout_count}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_sweep("sweep_after_reset");
        check_phase(6);
        val[0] = 16'd53;
        run_sweep("sweep_after_reset2");
        check_phase(7);
        $display("test done: total=%0d bad=%0d", total_n, bad_n);
        $finish;
    end
endmodule
